// File: rtl/stopwatch_pkg.sv
// Shared constants and helpers for the MM:SS stopwatch: 7-seg patterns, field select, BCD split.
package stopwatch_pkg;

    localparam int unsigned MAX_VAL = 59;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] BLANK = 7'b1111111;

    typedef enum logic {
        SelMin = 1'b0,
        SelSec = 1'b1
    } sel_e;

    function automatic int unsigned cnt_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

    function automatic logic [5:0] inc_mod60(input logic [5:0] v);
        return (v == 6'(MAX_VAL)) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [3:0] bcd_tens(input logic [5:0] v);
        logic [5:0] t;
        t = v / 6'd10;
        return t[3:0];
    endfunction

    function automatic logic [3:0] bcd_ones(input logic [5:0] v);
        logic [5:0] o;
        o = v % 6'd10;
        return o[3:0];
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Board-facing pins of the stopwatch: raw buttons/switches in, multiplexed 7-seg out.
interface stopwatch_if;
    logic       btnS;
    logic [7:0] sw;
    logic [6:0] seg;
    logic [3:0] an;

    modport master (output btnS, output sw, input seg, input an);
    modport slave  (input btnS, input sw, output seg, output an);
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stable-level debouncer; emits a one-cycle pulse on an accepted rise.
module btn_debounce #(
    parameter int unsigned DEB_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);
    import stopwatch_pkg::*;

    localparam int unsigned CW = cnt_width(DEB_CYC);

    logic          s1_q, s2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise_q, rise_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
        end else begin
            s1_q     <= btn;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
        end
    end

    // Level is accepted once the synchronised input has differed for DEB_CYC samples in a row
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = 1'b0;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEB_CYC - 1)) begin
            cnt_d    = '0;
            stable_d = s2_q;
            rise_d   = s2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/stopwatch_clock.sv
// Stopwatch MM:SS top level: dividers, run/adjust counting, digit scan and registered 7-seg decode.
// Define STOPWATCH_BLINK_EN to blank the selected field on alternate blink phases while adjusting.
module stopwatch_clock #(
    parameter int unsigned SEC_DIV   = 100_000_000,
    parameter int unsigned ADJ_DIV   = 50_000_000,
    parameter int unsigned BLINK_DIV = 25_000_000,
    parameter int unsigned SCAN_DIV  = 100_000,
    parameter int unsigned DEB_CYC   = 1_000_000
) (
    input logic        clk,
    input logic        btnR,
    stopwatch_if.slave io
);
    import stopwatch_pkg::*;

    localparam int unsigned SEC_W  = cnt_width(SEC_DIV);
    localparam int unsigned ADJ_W  = cnt_width(ADJ_DIV);
    localparam int unsigned SCAN_W = cnt_width(SCAN_DIV);

    // Switch synchroniser; only sw[1:0] carry meaning
    logic [1:0] sw_s1_q, sw_s2_q;
    logic       adj;
    sel_e       sel;

    always_ff @(posedge clk or negedge btnR) begin
        if (!btnR) begin
            sw_s1_q <= '0;
            sw_s2_q <= '0;
        end else begin
            sw_s1_q <= io.sw[1:0];
            sw_s2_q <= sw_s1_q;
        end
    end

    assign adj = sw_s2_q[1];
    assign sel = sel_e'(sw_s2_q[0]);

    logic pause_rise;

    btn_debounce #(
        .DEB_CYC(DEB_CYC)
    ) u_btn_debounce (
        .clk  (clk),
        .rst_n(btnR),
        .btn  (io.btnS),
        .rise (pause_rise)
    );

    // Free-running dividers
    logic [SEC_W-1:0]  sec_cnt_q;
    logic [ADJ_W-1:0]  adj_cnt_q;
    logic [SCAN_W-1:0] scan_cnt_q;
    logic              sec_tick, adj_tick, scan_tick;

    assign sec_tick  = (sec_cnt_q == SEC_W'(SEC_DIV - 1));
    assign adj_tick  = (adj_cnt_q == ADJ_W'(ADJ_DIV - 1));
    assign scan_tick = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge btnR) begin
        if (!btnR) begin
            sec_cnt_q  <= '0;
            adj_cnt_q  <= '0;
            scan_cnt_q <= '0;
        end else begin
            sec_cnt_q  <= sec_tick ? '0 : sec_cnt_q + 1'b1;
            adj_cnt_q  <= adj_tick ? '0 : adj_cnt_q + 1'b1;
            scan_cnt_q <= scan_tick ? '0 : scan_cnt_q + 1'b1;
        end
    end

    // Time state
    logic [5:0] min_q, min_d;
    logic [5:0] sec_q, sec_d;
    logic       run_q, run_d;

    always_ff @(posedge clk or negedge btnR) begin
        if (!btnR) begin
            min_q <= '0;
            sec_q <= '0;
            run_q <= 1'b1;
        end else begin
            min_q <= min_d;
            sec_q <= sec_d;
            run_q <= run_d;
        end
    end

    // Counting looks at run_q, so a tick coinciding with a pause toggle uses the old run state
    always_comb begin
        min_d = min_q;
        sec_d = sec_q;
        run_d = run_q ^ pause_rise;
        if (adj) begin
            if (adj_tick) begin
                if (sel == SelSec) begin
                    sec_d = inc_mod60(sec_q);
                end else begin
                    min_d = inc_mod60(min_q);
                end
            end
        end else if (sec_tick && run_q) begin
            sec_d = inc_mod60(sec_q);
            if (sec_q == 6'(MAX_VAL)) begin
                min_d = inc_mod60(min_q);
            end
        end
    end

    // Digit scan
    logic [1:0] idx_q;

    always_ff @(posedge clk or negedge btnR) begin
        if (!btnR) begin
            idx_q <= 2'd0;
        end else if (scan_tick) begin
            idx_q <= idx_q + 2'd1;
        end
    end

    logic [3:0] digit;

    always_comb begin
        digit = 4'd0;
        unique case (idx_q)
            2'd0:    digit = bcd_ones(sec_q);
            2'd1:    digit = bcd_tens(sec_q);
            2'd2:    digit = bcd_ones(min_q);
            2'd3:    digit = bcd_tens(min_q);
            default: digit = 4'd0;
        endcase
    end

    logic blank;

`ifdef STOPWATCH_BLINK_EN
    localparam int unsigned BLINK_W = cnt_width(BLINK_DIV);

    logic [BLINK_W-1:0] blink_cnt_q;
    logic               blink_tick;
    logic               blink_on_q;
    logic               sel_digit;

    assign blink_tick = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));

    always_ff @(posedge clk or negedge btnR) begin
        if (!btnR) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            blink_cnt_q <= blink_tick ? '0 : blink_cnt_q + 1'b1;
            if (blink_tick) begin
                blink_on_q <= ~blink_on_q;
            end
        end
    end

    // Seconds occupy scan positions 0-1, minutes 2-3
    assign sel_digit = (sel == SelSec) ? ~idx_q[1] : idx_q[1];
    assign blank     = adj & ~blink_on_q & sel_digit;
`else
    assign blank = 1'b0;
`endif

    logic unused;
    assign unused = ^{io.sw[7:2], (BLINK_DIV == 0)};

    // Registered display outputs
    logic [3:0] an_q;
    logic [6:0] seg_q;

    always_ff @(posedge clk or negedge btnR) begin
        if (!btnR) begin
            an_q  <= 4'b1111;
            seg_q <= BLANK;
        end else begin
            an_q  <= ~(4'b0001 << idx_q);
            seg_q <= blank ? BLANK : seg_decode(digit);
        end
    end

    assign io.an  = an_q;
    assign io.seg = seg_q;

endmodule

// File: tb/tb_stopwatch_clock.sv
// Scoreboard bench for stopwatch_clock: expected MM:SS frames are queued by the stimulus and
// compared digit by digit by a monitor as the display scans.
module tb_stopwatch_clock;

    typedef struct {
        int mins;
        int secs;
    } frame_t;

    localparam logic [6:0] SEG_TAB [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic clk  = 1'b0;
    logic btnR = 1'b0;

    stopwatch_if sw_if ();

    stopwatch_clock #(
        .SEC_DIV  (8),
        .ADJ_DIV  (4),
        .BLINK_DIV(2),
        .SCAN_DIV (2),
        .DEB_CYC  (3)
    ) dut (
        .clk (clk),
        .btnR(btnR),
        .io  (sw_if.slave)
    );

    always #5 clk = ~clk;

    frame_t exp_q[$];
    bit     mon_busy = 1'b0;
    int     checks   = 0;
    int     failures = 0;
    int     t        = 0;

    function automatic int digit_of(input frame_t f, input int d);
        case (d)
            0:       return f.secs % 10;
            1:       return f.secs / 10;
            2:       return f.mins % 10;
            default: return f.mins / 10;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // t counts posedges since the last reset release; stimulus acts 1 time unit after an edge
    task automatic step_to(input int target);
        while (t < target) begin
            @(posedge clk);
            #1;
            t++;
        end
    endtask

    task automatic set_sw(input int at, input logic [7:0] v);
        step_to(at);
        sw_if.sw = v;
    endtask

    task automatic expect_frame(input int at, input int mins, input int secs);
        step_to(at);
        exp_q.push_back('{mins: mins, secs: secs});
    endtask

    task automatic press(input int at, input int len);
        step_to(at);
        sw_if.btnS = 1'b1;
        step_to(at + len);
        sw_if.btnS = 1'b0;
    endtask

    // Monitor: a frame starts when digit 0 is enabled; each later digit is taken when an changes
    initial begin : monitor
        frame_t     f;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic [3:0] prev_an;
        int         waited;
        prev_an = 4'b1111;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                mon_busy = 1'b1;
                f = exp_q.pop_front();
                waited = 0;
                while (sw_if.an != 4'b1110 && waited < 32) begin
                    @(negedge clk);
                    waited++;
                end
                for (int d = 0; d < 4; d++) begin
                    if (d > 0) begin
                        waited = 0;
                        while (sw_if.an == prev_an && waited < 8) begin
                            @(negedge clk);
                            waited++;
                        end
                    end
                    exp_an  = ~(4'b0001 << d);
                    exp_seg = SEG_TAB[digit_of(f, d)];
                    checks++;
                    if (sw_if.an !== exp_an || sw_if.seg !== exp_seg) begin
                        failures++;
                        $display("FAIL frame %02d:%02d digit %0d: an=%b seg=%b, expected an=%b seg=%b",
                                 f.mins, f.secs, d, sw_if.an, sw_if.seg, exp_an, exp_seg);
                    end
                    prev_an = sw_if.an;
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stimulus
        int waited;
        int blank_sel;
        int blank_other;
        sw_if.btnS = 1'b0;
        sw_if.sw   = 8'h00;

        // Reset state, then a reset asserted mid-count
        repeat (3) @(posedge clk);
        #1;
        check("reset_an", 32'(sw_if.an), 32'h0000000f);
        check("reset_seg", 32'(sw_if.seg), 32'h0000007f);
        btnR = 1'b1;
        repeat (30) @(posedge clk);
        #3;
        btnR = 1'b0;
        #1;
        check("async_reset_an", 32'(sw_if.an), 32'h0000000f);
        check("async_reset_seg", 32'(sw_if.seg), 32'h0000007f);
        repeat (2) @(posedge clk);
        #1;
        btnR = 1'b1;
        t = 0;

        // Counting: first frame 00:00, 60 ticks later 01:00
        expect_frame(0, 0, 0);
        expect_frame(480, 1, 0);

        // Pause: toggle lands mid-second so the frozen value is unambiguous
        press(518, 8);
        expect_frame(600, 1, 5);
        expect_frame(700, 1, 5);
        press(710, 1);
        expect_frame(760, 1, 5);
        press(798, 8);
        expect_frame(880, 1, 15);
        press(894, 8);

        // Adjust while paused; switch changes on 4-cycle boundaries so adj tick counts are exact
        set_sw(912, 8'b10);
        set_sw(920, 8'b00);
        expect_frame(920, 3, 17);
        set_sw(928, 8'b10);
        set_sw(1156, 8'b11);
        set_sw(1320, 8'b00);
        expect_frame(1320, 0, 58);
        set_sw(1336, 8'b11);
        set_sw(1340, 8'b00);
        expect_frame(1344, 0, 59);
        set_sw(1352, 8'b11);
        set_sw(1356, 8'b00);
        expect_frame(1360, 0, 0);
        set_sw(1368, 8'b11);
        set_sw(1372, 8'b00);
        expect_frame(1376, 0, 1);

        // Scan/decode of 12:34
        set_sw(1384, 8'b10);
        set_sw(1432, 8'b11);
        set_sw(1564, 8'b00);
        expect_frame(1568, 12, 34);

        // 59:59 wraps to 00:00 on the next count tick
        set_sw(1576, 8'b10);
        set_sw(1764, 8'b11);
        set_sw(1864, 8'b00);
        expect_frame(1872, 59, 59);
        press(1878, 8);
        expect_frame(1888, 0, 0);
        expect_frame(1896, 0, 1);

        waited = 0;
        while ((exp_q.size() != 0 || mon_busy) && waited < 200) begin
            @(posedge clk);
            waited++;
        end
        step_to(t + waited);
        if (exp_q.size() != 0 || mon_busy) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: %0d frames pending, expected 0", exp_q.size());
        end

        // Blanking of the selected field while adjusting seconds
        set_sw(t + 4, 8'b11);
        step_to(t + 8);
        blank_sel   = 0;
        blank_other = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sw_if.seg == 7'b1111111) begin
                if (sw_if.an == 4'b1110 || sw_if.an == 4'b1101) blank_sel++;
                if (sw_if.an == 4'b1011 || sw_if.an == 4'b0111) blank_other++;
            end
        end
`ifdef STOPWATCH_BLINK_EN
        check("blink_sel_blanked", 32'(blank_sel != 0), 32'd1);
`else
        check("no_blink_sel", 32'(blank_sel), 32'd0);
`endif
        check("blink_other_shown", 32'(blank_other), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
